// File: rtl/pipe_cpa.sv
// pipe_cpa: pipelined carry-propagate adder with ready/valid handshakes.
// Each stage adds one GROUP-bit slice using the carry registered by the
// stage before it. Operand slices that are not yet consumed travel down the
// pipe, and finished sum slices are carried along. The whole result therefore
// leaves the last stage aligned.
// Optional feature: define PIPE_CPA_SUB_EN to add a 'sub' input that turns the
// operation into a - b (with ci acting as an inverted borrow-in).
module pipe_cpa #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef PIPE_CPA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = (GROUP > 0) ? WIDTH / GROUP : 1;

    if (GROUP < 1 || WIDTH < GROUP || (WIDTH % GROUP) != 0) begin : g_bad_cfg
        $error("pipe_cpa: WIDTH must be a positive multiple of GROUP and GROUP >= 1");
    end

    logic             advance;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] b_eff;
    logic             ci_eff;
    logic             ovf_q;
    logic             msb_a;
    logic             msb_b;
    logic             msb_s;
    logic             ovf_d;

    // Subtraction is folded in at capture time: invert b and the carry-in.
`ifdef PIPE_CPA_SUB_EN
    assign a_eff  = a;
    assign b_eff  = sub ? ~b : b;
    assign ci_eff = ci ^ sub;
`else
    assign a_eff  = a;
    assign b_eff  = b;
    assign ci_eff = ci;
`endif

    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Stage k consumes the lowest remaining slice of its source vector. The
    // source vector interleaves slices as {..., a_slice, b_slice, carry}, so
    // dropping one consumed slice is a plain shift.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int SRC  = WIDTH - k * GROUP;
        localparam int REM  = SRC - GROUP;
        localparam int RW   = 2 * REM + 1;
        localparam int DONE = (k + 1) * GROUP;

        logic [2*SRC:0]  src;
        logic            valid_in;
        logic [GROUP:0]  grp_sum;
        logic [DONE-1:0] sum_d;
        logic [RW-1:0]   rem_d;
        logic            valid_q;
        logic [DONE-1:0] sum_q;
        logic [RW-1:0]   rem_q;

        if (k == 0) begin : g_head
            // Pack the incoming operands into the interleaved slice layout.
            always_comb begin
                src    = '0;
                src[0] = ci_eff;
                for (int j = 0; j < STAGES; j++) begin
                    src[2*GROUP*j+1 +: GROUP]       = b_eff[GROUP*j +: GROUP];
                    src[2*GROUP*j+GROUP+1 +: GROUP] = a_eff[GROUP*j +: GROUP];
                end
            end
            assign valid_in = in_valid;
            assign sum_d    = grp_sum[GROUP-1:0];
        end else begin : g_tail
            assign src      = g_stage[k-1].rem_q;
            assign valid_in = g_stage[k-1].valid_q;
            assign sum_d    = {grp_sum[GROUP-1:0], g_stage[k-1].sum_q};
        end

        assign grp_sum = {1'b0, src[2*GROUP:GROUP+1]} + {1'b0, src[GROUP:1]}
                       + {{GROUP{1'b0}}, src[0]};
        assign rem_d   = RW'({src[2*SRC:1] >> (2 * GROUP), grp_sum[GROUP]});

        // Stage register: moves only when the whole pipe advances.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                sum_q   <= '0;
                rem_q   <= '0;
            end else if (advance) begin
                valid_q <= valid_in;
                sum_q   <= sum_d;
                rem_q   <= rem_d;
            end
        end
    end

    // Signed overflow for the top slice: the operand signs agree and the sum sign differs.
    assign msb_a = g_stage[STAGES-1].src[2*GROUP];
    assign msb_b = g_stage[STAGES-1].src[GROUP];
    assign msb_s = g_stage[STAGES-1].grp_sum[GROUP-1];
    assign ovf_d = (msb_a & msb_b & ~msb_s) | (~msb_a & ~msb_b & msb_s);

    // Overflow flag is registered alongside the last stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (advance) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign s         = g_stage[STAGES-1].sum_q;
    assign cout      = g_stage[STAGES-1].rem_q[0];
    assign ovf       = ovf_q;

endmodule

// File: doc/pipe_cpa.md
PIPE_CPA -- requirements
Module: pipe_cpa

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and sum width in bits.
REQ-002 SHALL have parameter GROUP, default 4, bits added per pipeline stage.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operands a/b/ci are valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, block accepts an operand set this cycle.
REQ-007 SHALL have port a, input, WIDTH, operand A.
REQ-008 SHALL have port b, input, WIDTH, operand B.
REQ-009 SHALL have port ci, input, 1, carry-in to bit 0.
REQ-010 SHALL have port out_valid, output, 1, s/cout/ovf hold a valid result.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts the result this cycle.
REQ-012 SHALL have port s, output, WIDTH, sum.
REQ-013 SHALL have port cout, output, 1, carry out of bit WIDTH-1.
REQ-014 SHALL have port ovf, output, 1, signed overflow: carry into bit WIDTH-1 XOR cout.

Function
REQ-015 SHALL be built as STAGES = WIDTH/GROUP pipeline stages; stage k adds bits [k*GROUP+GROUP-1 : k*GROUP] using the carry registered by stage k-1 (ci for stage 0).
REQ-016 SHALL skew inputs: operand bits of group k are delayed k cycles before stage k; sum bits of group k are delayed STAGES-1-k cycles so that all of s emerges aligned.
REQ-017 SHALL define advance = ~out_valid | out_ready; every pipeline register, including per-stage valid bits, loads only when advance is 1.
REQ-018 SHALL drive in_ready = advance, combinationally; an operand set is accepted when in_valid & in_ready.
REQ-019 SHALL present a result with out_valid=1 exactly STAGES cycles after acceptance when advance stays 1 (latency 4 with defaults), accepting one new operand set per cycle.
REQ-020 SHALL hold s, cout, ovf and out_valid stable while out_valid=1 and out_ready=0; no result is dropped or duplicated.
REQ-021 SHALL propagate bubbles: a cycle with in_valid=0 while advancing inserts a stage with valid=0.
REQ-022 SHALL compute {cout, s} = a + b + ci modulo 2^(WIDTH+1), identical to a non-pipelined ripple adder.
REQ-023 SHALL produce a compile-time error when WIDTH is not a positive multiple of GROUP or GROUP < 1.
REQ-024 SHALL produce one single-stage register (latency 1) when GROUP = WIDTH.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, clear all stage valid bits, out_valid, s, cout and ovf to 0, regardless of in_valid or out_ready.
REQ-026 SHALL discard every in-flight operand set on reset; in_ready reads 1 in the first cycle after reset.

Configuration
REQ-027 SHALL compile in a subtract input when macro PIPE_CPA_SUB_EN is defined: extra port sub, input, 1, captured with the operands.
REQ-028 SHALL, with PIPE_CPA_SUB_EN and sub=1, compute a + ~b + (ci XOR 1), i.e. a - b - (ci XOR 0) becomes a - b when ci=0; cout=1 means no borrow.
REQ-029 SHALL, without PIPE_CPA_SUB_EN, have no sub port and behave as pure addition.

Verification (WIDTH=16, GROUP=4)
REQ-030 SHALL cover: a=16'hFFFF, b=16'h0001, ci=0, out_ready=1 -> 4 cycles later s=16'h0000, cout=1, ovf=0.
REQ-031 SHALL cover: a=16'h7FFF, b=16'h0001, ci=0 -> s=16'h8000, cout=0, ovf=1.
REQ-032 SHALL cover: back-to-back operand sets (1+1, 2+2, 3+3, 4+4) with out_ready=1 -> s=2,4,6,8 on four consecutive cycles starting 4 cycles after the first.
REQ-033 SHALL cover: out_ready=0 for 6 cycles while in_valid=1 -> in_ready=0 once out_valid=1, s constant; after out_ready=1, all accepted results emerge in order with none lost.
REQ-034 SHALL cover: rst=1 with 3 sets in flight -> out_valid=0, s=0 next cycle; no stale result appears afterward.
REQ-035 SHALL cover, with PIPE_CPA_SUB_EN: a=16'h0005, b=16'h0007, ci=0, sub=1 -> s=16'hFFFE, cout=0.
